io_intc: RTL and testbench



---
 rtl/io_intc_pkg.sv | 27 ++
 rtl/io_intc_prio_enc.sv | 25 ++
 rtl/io_intc.sv | 175 +++++++++++++++++
 tb/tb_io_intc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_intc_pkg.sv
// Shared definitions for io_intc: FSM encoding, register offsets and constants.
// Optional acknowledge timeout is selected with IO_INTC_ACK_TIMEOUT_EN.
package io_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKD = 2'd2
    } state_t;

    // Byte offsets within the 1 KiB decoded window (address bits [9:0]).
    localparam logic [9:0] OFF_STATUS = 10'h000;
    localparam logic [9:0] OFF_MASK   = 10'h004;
    localparam logic [9:0] OFF_VECTOR = 10'h008;
    localparam logic [9:0] OFF_CLEAR  = 10'h00C;
    localparam logic [9:0] OFF_SWINT  = 10'h010;
    localparam logic [9:0] OFF_DATA   = 10'h100;

    localparam logic [31:0] VECTOR_NONE = 32'hFFFF_FFFF;
    localparam int          TFLAG_BIT   = 30;
    localparam int          INTR_BIT    = 31;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_intc_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req and whether any bit is set.
module io_intc_prio_enc
    import io_intc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ID_W   = id_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    output logic [ID_W-1:0]   id,
    output logic              valid
);

    // Scanning from the top down leaves the lowest set index as the final winner.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_intc.sv
// N-channel memory-mapped IO controller with scratch data window and fixed-priority
// interrupt controller. Define IO_INTC_ACK_TIMEOUT_EN to compile in the intr withdrawal timeout.
module io_intc
    import io_intc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 64,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_cs,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [31:0] io_address,
    input  logic [31:0] io_d_in,
    output logic [31:0] io_out,
    input  logic [NUM_CH-1:0] irq_src,
    output logic        intr,
    input  logic        inta
);

    localparam int ID_W  = id_width(NUM_CH);
    localparam int IDX_W = id_width(DEPTH);

    state_t state, state_next;

    logic [NUM_CH-1:0] pending, mask, irq_q, masked;
    logic [NUM_CH-1:0] edges, sw_set, sw_clr, ack_clr;
    logic [31:0]       vector;
    logic              tflag;
    logic              req, ack, timeout_hit, timeout_fire;
    logic [ID_W-1:0]   ack_id;
    logic              ack_valid;

    logic [9:0]        off;
    logic [10:0]       data_off;
    logic              data_hit, wr_en;
    logic [IDX_W-1:0]  data_idx;
    logic [31:0]       rdata, status;
    logic [31:0]       mem [DEPTH];

    // Address decode: bits [1:0] are dropped so every access is word aligned.
    assign off      = {io_address[9:2], 2'b00};
    assign data_off = {1'b0, off} - {1'b0, OFF_DATA};
    assign data_hit = (off >= OFF_DATA) && (data_off < 11'(4 * DEPTH));
    assign data_idx = data_off[IDX_W+1:2];
    assign wr_en    = io_cs & io_wr;

    assign masked = pending & mask;
    assign req    = |masked;
    assign edges  = irq_src & ~irq_q;
    assign sw_set = (wr_en && off == OFF_SWINT) ? io_d_in[NUM_CH-1:0] : '0;
    assign sw_clr = (wr_en && off == OFF_CLEAR) ? io_d_in[NUM_CH-1:0] : '0;
    assign ack_clr = (ack && ack_valid) ? (NUM_CH'(1) << ack_id) : '0;

    io_intc_prio_enc #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_prio (
        .req   (masked),
        .id    (ack_id),
        .valid (ack_valid)
    );

`ifdef IO_INTC_ACK_TIMEOUT_EN
    logic [7:0] tcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state == ST_REQ) begin
            tcnt <= tcnt + 8'd1;
        end else begin
            tcnt <= '0;
        end
    end

    assign timeout_hit = (tcnt == 8'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tflag <= 1'b0;
        end else if (timeout_fire) begin
            tflag <= 1'b1;
        end else if (wr_en && off == OFF_CLEAR && io_d_in[TFLAG_BIT]) begin
            tflag <= 1'b0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = (ACK_TIMEOUT == 0);
    assign timeout_hit = 1'b0;
    assign tflag       = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^{io_address[31:10], io_address[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req) state_next = ST_REQ;
            ST_REQ: begin
                if (inta)             state_next = ST_ACKD;
                else if (!req)        state_next = ST_IDLE;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_ACKD: if (!inta) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        intr         = (state == ST_REQ);
        ack          = (state == ST_REQ) && inta;
        timeout_fire = (state == ST_REQ) && !inta && req && timeout_hit;
    end

    // Sets win over both software clear and acknowledge clear so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            mask    <= '1;
            irq_q   <= '0;
            vector  <= VECTOR_NONE;
        end else begin
            pending <= (pending & ~sw_clr & ~ack_clr) | edges | sw_set;
            irq_q   <= irq_src;
            if (wr_en && off == OFF_MASK) begin
                mask <= io_d_in[NUM_CH-1:0];
            end
            if (ack && ack_valid) begin
                vector <= 32'(ack_id);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && data_hit) begin
            mem[data_idx] <= io_d_in;
        end
    end

    always_comb begin
        status                 = '0;
        status[NUM_CH-1:0]     = pending;
        status[TFLAG_BIT]      = tflag;
        status[INTR_BIT]       = intr;
    end

    always_comb begin
        rdata = '0;
        if (off == OFF_STATUS) begin
            rdata = status;
        end else if (off == OFF_MASK) begin
            rdata = 32'(mask);
        end else if (off == OFF_VECTOR) begin
            rdata = vector;
        end else if (data_hit) begin
            rdata = mem[data_idx];
        end
    end

    assign io_out = (io_cs && io_rd) ? rdata : '0;

endmodule

// File: tb/tb_io_intc.sv
// Self-checking bench for io_intc: directed steps followed by randomized bus/IRQ traffic
// compared against a behavioural model. Timeout checks follow IO_INTC_ACK_TIMEOUT_EN.
module tb_io_intc;

    localparam int NUM_CH      = 4;
    localparam int DEPTH       = 64;
    localparam int ACK_TIMEOUT = 10;

    logic              clk = 1'b0;
    logic              reset, io_cs, io_rd, io_wr, inta;
    logic [31:0]       io_address, io_d_in, io_out;
    logic [NUM_CH-1:0] irq_src;
    logic              intr;

    io_intc #(
        .NUM_CH      (NUM_CH),
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .io_cs      (io_cs),
        .io_rd      (io_rd),
        .io_wr      (io_wr),
        .io_address (io_address),
        .io_d_in    (io_d_in),
        .io_out     (io_out),
        .irq_src    (irq_src),
        .intr       (intr),
        .inta       (inta)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [NUM_CH-1:0] m_pend, m_mask, m_irq_q;
    logic [31:0]       m_vec;
    logic              m_tflag, m_intr, m_acked;
    int                m_cnt;
    logic [31:0]       mmem [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [NUM_CH-1:0] act, setb, clrb, ackb, swb, nmask;
        logic [7:0] w;
        logic tset, tclr;
        int lo;
        if (reset) begin
            m_pend = '0; m_mask = '1; m_irq_q = '0; m_vec = 32'hFFFF_FFFF;
            m_tflag = 1'b0; m_intr = 1'b0; m_acked = 1'b0; m_cnt = 0;
            return;
        end
        act = m_pend & m_mask;
        setb = irq_src & ~m_irq_q;
        clrb = '0; ackb = '0; swb = '0; nmask = m_mask; tset = 1'b0; tclr = 1'b0;
        w = io_address[9:2];
        if (io_cs && io_wr) begin
            if (w == 8'd1) nmask = io_d_in[NUM_CH-1:0];
            if (w == 8'd3) begin clrb = io_d_in[NUM_CH-1:0]; tclr = io_d_in[30]; end
            if (w == 8'd4) swb = io_d_in[NUM_CH-1:0];
            if (w >= 8'd64 && int'(w) < 64 + DEPTH) mmem[int'(w) - 64] = io_d_in;
        end
        if (m_intr) begin
            if (inta) begin
                lo = lowest(act);
                if (lo >= 0) begin m_vec = 32'(lo); ackb[lo] = 1'b1; end
                m_intr = 1'b0; m_acked = 1'b1;
            end else if (act == '0) begin
                m_intr = 1'b0;
`ifdef IO_INTC_ACK_TIMEOUT_EN
            end else if (m_cnt == ACK_TIMEOUT - 1) begin
                m_intr = 1'b0; tset = 1'b1;
            end else begin
                m_cnt++;
`endif
            end
        end else if (m_acked) begin
            if (!inta) m_acked = 1'b0;
        end else if (act != '0) begin
            m_intr = 1'b1; m_cnt = 0;
        end
        m_pend  = (m_pend & ~clrb & ~ackb) | setb | swb;
        m_mask  = nmask;
        m_irq_q = irq_src;
        if (tset) m_tflag = 1'b1;
        else if (tclr) m_tflag = 1'b0;
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        logic [7:0] w;
        logic [31:0] r;
        w = a[9:2];
        r = '0;
        if (w == 8'd0) begin r[NUM_CH-1:0] = m_pend; r[30] = m_tflag; r[31] = m_intr; end
        else if (w == 8'd1) r = 32'(m_mask);
        else if (w == 8'd2) r = m_vec;
        else if (w >= 8'd64 && int'(w) < 64 + DEPTH) r = mmem[int'(w) - 64];
        return r;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("intr", {31'b0, intr}, {31'b0, m_intr});
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b0; io_address = a; io_d_in = d;
        tick();
        io_cs = 1'b0; io_wr = 1'b0;
    endtask

    // Directed read: checks against a fixed expected value and against the model.
    task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] exp);
        io_cs = 1'b1; io_rd = 1'b1; io_wr = 1'b0; io_address = a;
        #1;
        check(tag, io_out, exp);
        check({tag, "_model"}, io_out, exp_read(a));
        io_cs = 1'b0; io_rd = 1'b0;
    endtask

    task automatic rd_model(input logic [31:0] a);
        io_cs = 1'b1; io_rd = 1'b1; io_wr = 1'b0; io_address = a;
        #1;
        check("rand_read", io_out, exp_read(a));
        io_cs = 1'b0; io_rd = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        reset = 1'b1; io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0; inta = 1'b0;
        io_address = '0; io_d_in = '0; irq_src = '0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("intr_rst", {31'b0, intr}, 32'h0);
        rd_exp("status_rst", 32'h000, 32'h0000_0000);
        rd_exp("mask_rst",   32'h004, 32'h0000_000F);
        rd_exp("vector_rst", 32'h008, 32'hFFFF_FFFF);

        // Single interrupt on channel 2
        irq_src = 4'h4; tick();
        irq_src = 4'h0;
        check("intr_k", {31'b0, intr}, 32'h0);
        tick();
        check("intr_k1", {31'b0, intr}, 32'h1);
        rd_exp("status_req2", 32'h000, 32'h8000_0004);
        inta = 1'b1; tick();
        check("intr_ack2", {31'b0, intr}, 32'h0);
        rd_exp("vector_2", 32'h008, 32'h0000_0002);
        inta = 1'b0; tick();
        rd_exp("status_after2", 32'h000, 32'h0);

        // Two simultaneous sources: 1 serviced before 3
        irq_src = 4'hA; tick();
        irq_src = 4'h0; tick();
        check("intr_pair", {31'b0, intr}, 32'h1);
        inta = 1'b1; tick();
        rd_exp("vector_1", 32'h008, 32'h1);
        inta = 1'b0; tick();
        check("intr_gap", {31'b0, intr}, 32'h0);
        tick();
        check("intr_rearm", {31'b0, intr}, 32'h1);
        inta = 1'b1; tick();
        rd_exp("vector_3", 32'h008, 32'h3);
        inta = 1'b0; tick();
        rd_exp("status_after_pair", 32'h000, 32'h0);

        // Masking and software clear while requesting
        bus_wr(32'h004, 32'h0000_000E);
        irq_src = 4'h1; tick();
        irq_src = 4'h0; tick(); tick();
        check("intr_masked", {31'b0, intr}, 32'h0);
        rd_exp("status_masked", 32'h000, 32'h1);
        bus_wr(32'h004, 32'h0000_000F);
        tick();
        check("intr_unmask", {31'b0, intr}, 32'h1);
        bus_wr(32'h00C, 32'h1);
        tick();
        check("intr_cleared", {31'b0, intr}, 32'h0);
        rd_exp("status_cleared", 32'h000, 32'h0);

        // Data window and address decode
        bus_wr(32'h104, 32'hDEAD_BEEF);
        rd_exp("data_104", 32'h104, 32'hDEAD_BEEF);
        rd_exp("data_104_alias", 32'h107, 32'hDEAD_BEEF);
        io_cs = 1'b0; io_rd = 1'b1; io_address = 32'h104; #1;
        check("no_cs_read", io_out, 32'h0);
        io_rd = 1'b0;
        rd_exp("unmapped_020", 32'h020, 32'h0);
        rd_exp("unmapped_3fc", 32'h3FC, 32'h0);

        // SWINT / CLEAR precedence with everything masked
        bus_wr(32'h004, 32'h0);
        bus_wr(32'h010, 32'h4);
        rd_exp("swint", 32'h000, 32'h4);
        bus_wr(32'h00C, 32'h4);
        rd_exp("clear", 32'h000, 32'h0);
        irq_src = 4'h4;
        bus_wr(32'h00C, 32'h4);
        irq_src = 4'h0;
        rd_exp("set_beats_clear", 32'h000, 32'h4);
        bus_wr(32'h00C, 32'h4);

        // Acknowledge clear of a bit that is re-set in the same cycle
        bus_wr(32'h004, 32'hF);
        bus_wr(32'h010, 32'h4);
        tick();
        check("intr_sw", {31'b0, intr}, 32'h1);
        inta = 1'b1; irq_src = 4'h4; tick();
        inta = 1'b0; irq_src = 4'h0;
        rd_exp("vector_ack_set", 32'h008, 32'h2);
        rd_exp("set_beats_ack", 32'h000, 32'h4);
        tick(); tick();
        inta = 1'b1; tick();
        inta = 1'b0; tick();
        rd_exp("status_drained", 32'h000, 32'h0);

        // Unanswered request
        bus_wr(32'h010, 32'h1);
        tick();
        check("intr_noack", {31'b0, intr}, 32'h1);
`ifdef IO_INTC_ACK_TIMEOUT_EN
        repeat (ACK_TIMEOUT - 1) tick();
        check("intr_before_to", {31'b0, intr}, 32'h1);
        tick();
        check("intr_timeout", {31'b0, intr}, 32'h0);
        rd_exp("status_timeout", 32'h000, 32'h4000_0001);
        tick();
        check("intr_rereq", {31'b0, intr}, 32'h1);
        rd_exp("status_rereq", 32'h000, 32'hC000_0001);
`else
        repeat (ACK_TIMEOUT + 1) tick();
        check("intr_held", {31'b0, intr}, 32'h1);
        rd_exp("status_held", 32'h000, 32'h8000_0001);
`endif
        bus_wr(32'h00C, 32'h4000_0001);
        tick();
        rd_exp("status_final_clear", 32'h000, 32'h0);

        // Fill the data window so every word has a known value
        for (int i = 0; i < DEPTH; i++) bus_wr(32'h100 + 32'(4 * i), $urandom);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            irq_src = NUM_CH'($urandom);
            inta = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) < 2) begin
                case ($urandom_range(0, 4))
                    0: ra = 32'h004;
                    1: ra = 32'h00C;
                    2: ra = 32'h010;
                    default: ra = 32'h100 + 32'(4 * $urandom_range(0, DEPTH - 1));
                endcase
                bus_wr(ra, $urandom);
            end else begin
                tick();
                case ($urandom_range(0, 4))
                    0: ra = 32'h000;
                    1: ra = 32'h004;
                    2: ra = 32'h008;
                    3: ra = 32'h014;
                    default: ra = 32'h100 + 32'(4 * $urandom_range(0, DEPTH - 1));
                endcase
                rd_model(ra);
            end
        end
        inta = 1'b0; irq_src = '0;

        // Reset from an arbitrary state
        reset = 1'b1; tick();
        reset = 1'b0;
        check("intr_rst2", {31'b0, intr}, 32'h0);
        rd_exp("vector_rst2", 32'h008, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
